med_frame_ctrl: RTL and testbench

- Frame-level sequencer wrapped around the 3x3 median filter datapath.
- Tracks raw-stream timing and enables the filter per frame. Latches configuration only at frame boundaries.
- Counts output coordinates and muxes border pixels: delayed raw pixel or a constant. Emits the final aligned stream plus frame status.

---
 rtl/med_frame_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_med_frame_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/med_frame_ctrl.sv
// rtl/med_frame_ctrl.sv - frame sequencer around the 3x3 median datapath; optional line_err via MED_FRAME_ERR_EN
module med_frame_ctrl #(
   parameter int          H_ACT      = 128,
   parameter int          V_ACT      = 128,
   parameter int          LAT        = 4,
   parameter logic [7:0]  BORDER_VAL = 8'd0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_de,
   input  logic       i_hs,
   input  logic       i_vs,
   input  logic [7:0] iData,
   input  logic [7:0] med_data,
   input  logic       cfg_en,
   input  logic       cfg_border,
   output logic       flt_clken,
   output logic       o_de,
   output logic       o_hs,
   output logic       o_vs,
   output logic [7:0] oData,
   output logic       busy,
`ifdef MED_FRAME_ERR_EN
   output logic       line_err,
`endif
   output logic       frame_done
);

   localparam int XW = (H_ACT > 1) ? $clog2(H_ACT) : 1;
   localparam int YW = (V_ACT > 1) ? $clog2(V_ACT) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(H_ACT - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_ACT - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACTIVE = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic [LAT-1:0] de_sr;
   logic [LAT-1:0] hs_sr;
   logic [LAT-1:0] vs_sr;
   logic [7:0]     data_sr [LAT];

   logic          d_de;
   logic          d_hs;
   logic          d_vs;
   logic [7:0]    d_data;
   logic          d_de_q;
   logic          d_vs_q;
   logic          de_fall;
   logic          vs_rise;
   logic          i_vs_q;
   logic          raw_en;
   logic          sh_border;
   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic          done_now;
   logic [XW-1:0] x_cnt;
   logic [YW-1:0] y_cnt;
   logic          is_border;
   logic [7:0]    pix_nxt;

   assign d_de   = de_sr[LAT-1];
   assign d_hs   = hs_sr[LAT-1];
   assign d_vs   = vs_sr[LAT-1];
   assign d_data = data_sr[LAT-1];

   assign de_fall = d_de_q & ~d_de;
   assign vs_rise = d_vs & ~d_vs_q;

   // free-running LAT-deep delay of the raw stream, aligned with med_data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de_sr <= '0;
         hs_sr <= '0;
         vs_sr <= '0;
         for (int i = 0; i < LAT; i++) data_sr[i] <= '0;
      end else begin
         de_sr[0]   <= i_de;
         hs_sr[0]   <= i_hs;
         vs_sr[0]   <= i_vs;
         data_sr[0] <= iData;
         for (int i = 1; i < LAT; i++) begin
            de_sr[i]   <= de_sr[i-1];
            hs_sr[i]   <= hs_sr[i-1];
            vs_sr[i]   <= vs_sr[i-1];
            data_sr[i] <= data_sr[i-1];
         end
      end
   end

   // edge history for the delayed syncs and the raw vsync
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_de_q <= 1'b0;
         d_vs_q <= 1'b0;
         i_vs_q <= 1'b0;
      end else begin
         d_de_q <= d_de;
         d_vs_q <= d_vs;
         i_vs_q <= i_vs;
      end
   end

   // raw-side enable: primes the window generator LAT clocks before the state follows
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         raw_en <= 1'b0;
      else if (i_vs && !i_vs_q)
         raw_en <= cfg_en;
   end

   assign flt_clken = i_de & raw_en;

   // border mode is frozen at frame start; the enable is carried by the ACTIVE state itself
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sh_border <= 1'b0;
      else if (vs_rise)
         sh_border <= cfg_border;
   end

   // next state: completion pulses first, a coincident vsync then starts the new frame
   always_comb begin
      state_nxt = state;
      done_now  = 1'b0;
      case (state)
         S_IDLE: begin
            if (vs_rise && cfg_en) state_nxt = S_ACTIVE;
         end
         S_ACTIVE: begin
            if (de_fall && y_cnt == Y_LAST) begin
               done_now  = 1'b1;
               state_nxt = S_DONE;
            end
            if (vs_rise) state_nxt = cfg_en ? S_ACTIVE : S_IDLE;
         end
         S_DONE: begin
            if (vs_rise) state_nxt = cfg_en ? S_ACTIVE : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // state register and end-of-frame pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         frame_done <= done_now;
      end
   end

   assign busy = (state == S_ACTIVE);

   // saturating output coordinates on the delayed stream, restarted by every vsync
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (vs_rise) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (state == S_ACTIVE) begin
         if (d_de) begin
            if (x_cnt != X_LAST) x_cnt <= x_cnt + 1'b1;
         end else if (de_fall) begin
            x_cnt <= '0;
            if (y_cnt != Y_LAST) y_cnt <= y_cnt + 1'b1;
         end
      end
   end

   assign is_border = (x_cnt == '0) || (x_cnt == X_LAST) ||
                      (y_cnt == '0) || (y_cnt == Y_LAST);

   // pixel select: filtered interior, border from raw or constant, bypass outside ACTIVE
   always_comb begin
      pix_nxt = d_data;
      if (state == S_ACTIVE) begin
         if (!is_border)
            pix_nxt = med_data;
         else if (sh_border)
            pix_nxt = BORDER_VAL;
      end
   end

   // output register: fixed LAT+1 latency in every state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_de  <= 1'b0;
         o_hs  <= 1'b0;
         o_vs  <= 1'b0;
         oData <= '0;
      end else begin
         o_de  <= d_de;
         o_hs  <= d_hs;
         o_vs  <= d_vs;
         oData <= pix_nxt;
      end
   end

`ifdef MED_FRAME_ERR_EN
   logic x_full;
   logic x_ovf;
   logic run_bad;
   logic abort_bad;

   // x_cnt saturates, so track "reached H_ACT" and "went past it" separately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_full <= 1'b0;
         x_ovf  <= 1'b0;
      end else if (vs_rise || de_fall) begin
         x_full <= 1'b0;
         x_ovf  <= 1'b0;
      end else if (d_de) begin
         if (x_full) x_ovf <= 1'b1;
         if (x_cnt == X_LAST) x_full <= 1'b1;
      end
   end

   assign run_bad   = de_fall && !(x_full && !x_ovf);
   assign abort_bad = vs_rise && (y_cnt != Y_LAST);

   // sticky error; a new error on the starting vsync wins over the clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         line_err <= 1'b0;
      else if (state == S_ACTIVE && (run_bad || abort_bad))
         line_err <= 1'b1;
      else if (vs_rise && cfg_en)
         line_err <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_med_frame_ctrl.sv
// tb/tb_med_frame_ctrl.sv - scoreboard bench for med_frame_ctrl with frame-level reference model
module tb_med_frame_ctrl;

   localparam int         H      = 8;
   localparam int         V      = 8;
   localparam int         LAT    = 4;
   localparam logic [7:0] BVAL   = 8'd0;
   localparam logic [7:0] MEDX   = 8'h5A;
   localparam int         P_RND  = 0;
   localparam int         P_RAMP = 1;
   localparam int         P_IMP  = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       i_de, i_hs, i_vs;
   logic [7:0] iData, med_data;
   logic       cfg_en, cfg_border;
   logic       flt_clken, o_de, o_hs, o_vs, busy, frame_done;
   logic [7:0] oData;
`ifdef MED_FRAME_ERR_EN
   logic       line_err;
`endif

   med_frame_ctrl #(.H_ACT(H), .V_ACT(V), .LAT(LAT), .BORDER_VAL(BVAL)) dut (
      .clk(clk), .rst_n(rst_n), .i_de(i_de), .i_hs(i_hs), .i_vs(i_vs),
      .iData(iData), .med_data(med_data), .cfg_en(cfg_en), .cfg_border(cfg_border),
      .flt_clken(flt_clken), .o_de(o_de), .o_hs(o_hs), .o_vs(o_vs), .oData(oData),
      .busy(busy),
`ifdef MED_FRAME_ERR_EN
      .line_err(line_err),
`endif
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         due;
      logic       de, hs, vs, fd, busy, err;
      logic [7:0] data;
   } exp_t;

   exp_t       sbq[$];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] hist [256];

   // reference model state (frame-level)
   logic m_act = 0, m_bord = 0, m_err = 0, m_pde = 0, m_pvs = 0, raw_filter = 0;
   int   m_x = 0, m_y = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
      end
   endtask

   // monitor: pop the entry due this cycle and compare
   always @(negedge clk) begin
      if (rst_n) begin
         while (sbq.size() > 0 && sbq[0].due < cyc) begin
            void'(sbq.pop_front());
            checks++;
            errors++;
            $display("FAIL stale_entry cyc=%0d got=missed exp=compared", cyc);
         end
         if (sbq.size() > 0 && sbq[0].due == cyc) begin
            exp_t e;
            e = sbq.pop_front();
            chk("o_de", {7'd0, o_de}, {7'd0, e.de});
            chk("o_hs", {7'd0, o_hs}, {7'd0, e.hs});
            chk("o_vs", {7'd0, o_vs}, {7'd0, e.vs});
            chk("busy", {7'd0, busy}, {7'd0, e.busy});
            chk("frame_done", {7'd0, frame_done}, {7'd0, e.fd});
            if (e.de) chk("oData", oData, e.data);
`ifdef MED_FRAME_ERR_EN
            chk("line_err", {7'd0, line_err}, {7'd0, e.err});
`endif
         end
         chk("flt_clken", {7'd0, flt_clken}, {7'd0, i_de & raw_filter});
      end
   end

   // one raw clock: drive inputs, feed the stand-in filter, push the expected response
   task automatic step(input logic de, input logic hs, input logic vs, input logic [7:0] d);
      exp_t e;
      logic fall, rise, act0, set_err;
      int   xs, ys;
      @(posedge clk); #1;
      i_de = de; i_hs = hs; i_vs = vs; iData = d;
      hist[cyc & 255] = d;
      med_data = hist[(cyc - LAT) & 255] ^ MEDX;
      fall = m_pde && !de;
      rise = vs && !m_pvs;
      e.due = cyc + LAT + 1;
      e.de = de; e.hs = hs; e.vs = vs; e.fd = 1'b0; e.data = d;
      if (de && m_act) begin
         xs = (m_x < H - 1) ? m_x : H - 1;
         ys = (m_y < V - 1) ? m_y : V - 1;
         if (xs == 0 || xs == H - 1 || ys == 0 || ys == V - 1)
            e.data = m_bord ? BVAL : d;
         else
            e.data = d ^ MEDX;
      end
      act0 = m_act;
      set_err = act0 && ((fall && m_x != H) || (rise && ((m_y < V - 1) ? m_y : V - 1) != V - 1));
      if (de) m_x++;
      if (fall) begin
         if (m_act) begin
            m_y++;
            if (m_y == V) begin
               e.fd  = 1'b1;
               m_act = 1'b0;
            end
         end
         m_x = 0;
      end
      if (rise) begin
         m_act = cfg_en; m_bord = cfg_border; m_x = 0; m_y = 0; raw_filter = cfg_en;
      end
      if (set_err) m_err = 1'b1;
      else if (rise && cfg_en) m_err = 1'b0;
      e.busy = m_act;
      e.err  = m_err;
      m_pde = de;
      m_pvs = vs;
      sbq.push_back(e);
   endtask

   task automatic frame(input logic en, input logic bord, input int nlines, input int tail,
                        input logic jitter, input logic tog, input int pat);
      logic [7:0] px;
      int len;
      cfg_en = en;
      cfg_border = bord;
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 8'($urandom));
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'($urandom));
      for (int l = 0; l < nlines; l++) begin
         len = H;
         if (jitter && $urandom_range(0, 3) == 0) len = H - 1 + $urandom_range(0, 2);
         for (int i = 0; i < 4; i++) step(1'b0, i < 2, 1'b0, 8'($urandom));
         for (int p = 0; p < len; p++) begin
            if (tog && l == 2 && p == 3) begin
               cfg_border = !cfg_border;
               cfg_en = 1'($urandom_range(0, 1));
            end
            case (pat)
               P_RAMP:  px = 8'(l * H + p);
               P_IMP:   px = (l == V / 2 && p == H / 2) ? 8'd255 : 8'd10;
               default: px = 8'($urandom);
            endcase
            step(1'b1, 1'b0, 1'b0, px);
         end
      end
      for (int i = 0; i < tail; i++) step(1'b0, 1'b0, 1'b0, 8'($urandom));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_o_de"}, {7'd0, o_de}, 8'd0);
      chk({tag, "_o_hs"}, {7'd0, o_hs}, 8'd0);
      chk({tag, "_o_vs"}, {7'd0, o_vs}, 8'd0);
      chk({tag, "_oData"}, oData, 8'd0);
      chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
      chk({tag, "_frame_done"}, {7'd0, frame_done}, 8'd0);
      chk({tag, "_flt_clken"}, {7'd0, flt_clken}, 8'd0);
   endtask

   task automatic mid_reset();
      cfg_en = 1'b1;
      cfg_border = 1'b0;
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 8'($urandom));
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'($urandom));
      for (int l = 0; l < 3; l++) begin
         for (int i = 0; i < 4; i++) step(1'b0, i < 2, 1'b0, 8'($urandom));
         for (int p = 0; p < ((l == 2) ? H / 2 : H); p++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      i_de = 0; i_hs = 0; i_vs = 0; iData = 0;
      sbq.delete();
      m_act = 0; m_pde = 0; m_pvs = 0; m_err = 0; raw_filter = 0; m_x = 0; m_y = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 256; i++) hist[i] = 8'd0;
      rst_n = 0; i_de = 0; i_hs = 0; i_vs = 0; iData = 0; med_data = 0;
      cfg_en = 0; cfg_border = 0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      rst_n = 1;

      frame(1'b0, 1'b0, V, 3, 1'b0, 1'b0, P_RAMP);
      frame(1'b1, 1'b1, V, 3, 1'b0, 1'b0, P_IMP);
      frame(1'b1, 1'b0, V, 2, 1'b0, 1'b0, P_IMP);
      frame(1'b1, 1'b1, V, 0, 1'b0, 1'b1, P_RND);
      frame(1'b1, 1'b0, V, 2, 1'b0, 1'b0, P_RND);
      frame(1'b1, 1'b0, 3, 2, 1'b0, 1'b0, P_RND);
      frame(1'b1, 1'b1, V, 3, 1'b0, 1'b0, P_RND);
      for (int f = 0; f < 8; f++)
         frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, V - 1) : V,
               $urandom_range(0, 3), 1'b1, 1'($urandom_range(0, 1)), P_RND);
      mid_reset();
      frame(1'b1, 1'b1, V, 3, 1'b0, 1'b0, P_IMP);
      frame(1'b0, 1'b0, 2, 3, 1'b0, 1'b0, P_RND);
      for (int i = 0; i < LAT + 4; i++) step(1'b0, 1'b0, 1'b0, 8'd0);

      for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clk);
      if (sbq.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain cyc=%0d got=%0d_pending exp=0_pending", cyc, sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
